alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered ALU: successor to the 4-bit combinational ALU.
//  Accepts one operation per cycle over a valid/ready handshake and returns a result plus flags one cycle later.
//  An internal accumulator can supply operand A for chained operations.
//  Sits between the operand/control front end and the writeback path of the datapath.
// PARAMETERS
//  WIDTH   8   operand, result and accumulator width in bits (>=2)
//  CNT_W   16  width of the accepted-operation counter
// PORTS
//  clk        in   1      rising-edge clock, sole clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operation presented on op/a/b/use_acc
//  in_ready   out  1      block can accept an operation this cycle
//  op         in   3      opcode (see BEHAVIOUR)
//  a          in   WIDTH  operand A (ignored when use_acc=1)
//  b          in   WIDTH  operand B
//  use_acc    in   1      1: operand A := acc
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result this cycle
//  result     out  WIDTH  operation result
//  carry      out  1      ADD carry-out / SUB no-borrow; else 0
//  overflow   out  1      signed overflow for ADD/SUB; else 0
//  greater    out  1      CMP only: A>B unsigned; else 0
//  equal      out  1      CMP only: A==B; else 0
//  less       out  1      CMP only: A<B unsigned; else 0
//  zero       out  1      result == 0
//  illegal    out  1      op was 3'b111
//  acc        out  WIDTH  current accumulator value
//  op_count   out  CNT_W  number of accepted operations, wraps to 0
// BEHAVIOUR
//  - Reset (async, immediate): out_valid=0, result=0, all flags=0, acc=0, op_count=0.
//    in_ready=1 once rst deasserts. Any in-flight result is discarded.
//  - Handshake: in_ready = !out_valid | out_ready (combinational).
//    Accept = in_valid & in_ready. out_valid and result hold stable until out_ready=1.
//  - Latency: 1 cycle. The op accepted at edge N is output after edge N with out_valid=1.
//    Back-to-back accept with out_ready=1 held gives full throughput.
//  - Output clears: out_valid falls only on out_ready=1 with no simultaneous accept.
//    Simultaneous drain and accept replaces the output the same edge.
//  - Operand A = use_acc ? acc : a, sampled at accept. acc is read before its update at that edge.
//  - Opcodes; all arithmetic is modulo 2^WIDTH:
//      000 ADD    result=A+B; carry=bit WIDTH of sum
//      001 SUB    result=A+~B+1; carry=1 iff A>=B unsigned
//      010 CMP    result=A-B; greater/equal/less set, exactly one high
//      011 AND    result=A&B
//      100 OR     result=A|B
//      101 XOR    result=A^B
//      110 CLRACC result=0, acc:=0
//      111 illegal: result=0, illegal=1, acc unchanged
//  - overflow (ADD/SUB only) = sign(A) and sign(B') agree and sign(result) differs. B' = B for ADD, ~B for SUB.
//  - acc update: on accept, acc:=result for ADD, SUB, AND, OR and XOR. CMP and 111 leave acc unchanged.
//  - op_count increments on every accept, including illegal ops. It wraps from 2^CNT_W-1 to 0.
//  - No accept occurs while out_valid=1 and out_ready=0; op/a/b changes are ignored then.
// TESTING (WIDTH=4 unless noted)
//  1 Reset mid-stream. Accept ADD, then assert rst before the drain.
//    -> out_valid=0, acc=0 and op_count=0 immediately; in_ready=1 after release.
//  2 ADD a=9 b=8, out_ready=1 -> next cycle result=1, carry=1, overflow=1, zero=0, acc=1.
//    SUB a=3 b=5 -> result=14, carry=0, overflow=0.
//  3 CMP a=7 b=7 -> equal=1, greater=0, less=0, result=0, zero=1, acc unchanged.
//    CMP a=2 b=9 -> less=1.
//  4 Accumulate chain. CLRACC, then ADD use_acc=1 b=5 three times.
//    -> results 5, 10, 15, then a further ADD gives 4 with carry=1.
//  5 Backpressure. Hold out_ready=0 for 3 cycles with in_valid=1.
//    -> in_ready=0, result frozen, op_count +1 only. Then assert out_ready=1 with in_valid=1.
//    -> same-edge drain and accept, no bubble.
//  6 op=111 -> illegal=1, result=0. CNT_W=3: 9 accepts -> op_count=1 (wrap).

Source files
------------

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, 1-cycle latency and an accumulator
// that can stand in for operand A on chained operations.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             use_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             greater,
   output logic             equal,
   output logic             less,
   output logic             zero,
   output logic             illegal,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_CMP = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_CLR = 3'b110;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d, overflow_q, overflow_d;
   logic             greater_q, greater_d, equal_q, equal_d, less_q, less_d;
   logic             zero_q, zero_d, illegal_q, illegal_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH:0]   add_sum, sub_sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry, alu_ovf, alu_gt, alu_eq, alu_lt, alu_ill, alu_acc_we;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Operation datapath: result, flags and accumulator write enable for the presented op
   always_comb begin
      op_a       = use_acc ? acc_q : a;
      add_sum    = {1'b0, op_a} + {1'b0, b};
      sub_sum    = {1'b0, op_a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      alu_res    = {WIDTH{1'b0}};
      alu_carry  = 1'b0;
      alu_ovf    = 1'b0;
      alu_gt     = 1'b0;
      alu_eq     = 1'b0;
      alu_lt     = 1'b0;
      alu_ill    = 1'b0;
      alu_acc_we = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res    = add_sum[WIDTH-1:0];
            alu_carry  = add_sum[WIDTH];
            alu_ovf    = (op_a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
            alu_acc_we = 1'b1;
         end
         OP_SUB: begin
            alu_res    = sub_sum[WIDTH-1:0];
            alu_carry  = sub_sum[WIDTH];
            alu_ovf    = (op_a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != op_a[WIDTH-1]);
            alu_acc_we = 1'b1;
         end
         OP_CMP: begin
            alu_res = sub_sum[WIDTH-1:0];
            alu_gt  = op_a > b;
            alu_eq  = op_a == b;
            alu_lt  = op_a < b;
         end
         OP_AND: begin
            alu_res    = op_a & b;
            alu_acc_we = 1'b1;
         end
         OP_OR: begin
            alu_res    = op_a | b;
            alu_acc_we = 1'b1;
         end
         OP_XOR: begin
            alu_res    = op_a ^ b;
            alu_acc_we = 1'b1;
         end
         OP_CLR: begin
            alu_res    = {WIDTH{1'b0}};
            alu_acc_we = 1'b1;
         end
         default: begin
            alu_ill = 1'b1;
         end
      endcase
   end

   // Next-state: load on accept, drop valid on a bare drain, otherwise hold
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      carry_d     = carry_q;
      overflow_d  = overflow_q;
      greater_d   = greater_q;
      equal_d     = equal_q;
      less_d      = less_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         carry_d     = alu_carry;
         overflow_d  = alu_ovf;
         greater_d   = alu_gt;
         equal_d     = alu_eq;
         less_d      = alu_lt;
         zero_d      = (alu_res == {WIDTH{1'b0}});
         illegal_d   = alu_ill;
         cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (alu_acc_we) begin
            acc_d = alu_res;
         end else begin
            acc_d = acc_q;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output, accumulator and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= {WIDTH{1'b0}};
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         greater_q   <= 1'b0;
         equal_q     <= 1'b0;
         less_q      <= 1'b0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         acc_q       <= {WIDTH{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         overflow_q  <= overflow_d;
         greater_q   <= greater_d;
         equal_q     <= equal_d;
         less_q      <= less_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;
   assign greater   = greater_q;
   assign equal     = equal_q;
   assign less      = less_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign acc       = acc_q;
   assign op_count  = cnt_q;

endmodule
